// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared defaults and width helpers for the memory tag remapper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vx_mem_tag_remap_pkg;

    localparam int DEF_DATA_SIZE     = 64;
    localparam int DEF_ADDR_WIDTH    = 26;
    localparam int DEF_IN_TAG_WIDTH  = 12;
    localparam int DEF_NUM_ENTRIES   = 16;
    localparam int DEF_OUT_TAG_WIDTH = 4;

    // Compact ID width for a table of n entries.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Free-list pointers carry one extra wrap bit to tell full from empty.
    function automatic int ptr_width(input int n);
        return id_width(n) + 1;
    endfunction

endpackage

// File: rtl/vx_mem_tag_remap_freelist.sv
// Circular FIFO of free compact IDs, preloaded with 0..N-1 at reset.
// Latency: pop_id is combinational from the head; push/pop take effect at the next edge.
// Backpressure: none internally; caller must not pop when empty nor push when full.
module vx_mem_tag_remap_freelist
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pop_en,
    output logic [id_width(NUM_ENTRIES)-1:0]  pop_id,
    output logic                              empty,
    output logic                              full,
    input  logic                              push_en,
    input  logic [id_width(NUM_ENTRIES)-1:0]  push_id,
    output logic [ptr_width(NUM_ENTRIES)-1:0] count
);
    localparam int ID_W  = id_width(NUM_ENTRIES);
    localparam int PTR_W = ptr_width(NUM_ENTRIES);

    logic [ID_W-1:0]  mem_q [NUM_ENTRIES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    // Pointer advance; a pushed ID lands behind every older free ID.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (pop_en)  head_d = head_q + PTR_W'(1);
        if (push_en) tail_d = tail_q + PTR_W'(1);
    end

    // Storage and pointers; reset reloads IDs in ascending order, list full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) mem_q[i] <= ID_W'(i);
            head_q <= '0;
            tail_q <= PTR_W'(NUM_ENTRIES);
        end else begin
            if (push_en) mem_q[tail_q[ID_W-1:0]] <= push_id;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign pop_id = mem_q[head_q[ID_W-1:0]];
    assign empty  = (head_q == tail_q);
    assign full   = (head_q[ID_W] != tail_q[ID_W]) &&
                    (head_q[ID_W-1:0] == tail_q[ID_W-1:0]);
    assign count  = tail_q - head_q;

endmodule

// File: rtl/vx_mem_tag_remap.sv
// Swaps wide cluster memory tags for compact IDs on reads and restores them on responses.
// Latency: 0 cycles on both request and response paths (pure combinational pass-through).
// Backpressure: reads stall while no ID is free; writes always flow; unknown-ID responses are sunk.
module vx_mem_tag_remap
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int IN_TAG_WIDTH  = DEF_IN_TAG_WIDTH,
    parameter int NUM_ENTRIES   = DEF_NUM_ENTRIES,
    parameter int OUT_TAG_WIDTH = DEF_OUT_TAG_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_req_valid,
    input  logic                              in_req_rw,
    input  logic [ADDR_WIDTH-1:0]             in_req_addr,
    input  logic [DATA_SIZE*8-1:0]            in_req_data,
    input  logic [DATA_SIZE-1:0]              in_req_byteen,
    input  logic [IN_TAG_WIDTH-1:0]           in_req_tag,
    output logic                              in_req_ready,
    output logic                              out_req_valid,
    output logic                              out_req_rw,
    output logic [ADDR_WIDTH-1:0]             out_req_addr,
    output logic [DATA_SIZE*8-1:0]            out_req_data,
    output logic [DATA_SIZE-1:0]              out_req_byteen,
    output logic [OUT_TAG_WIDTH-1:0]          out_req_tag,
    input  logic                              out_req_ready,
    input  logic                              out_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]            out_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0]          out_rsp_tag,
    output logic                              out_rsp_ready,
    output logic                              in_rsp_valid,
    output logic [DATA_SIZE*8-1:0]            in_rsp_data,
    output logic [IN_TAG_WIDTH-1:0]           in_rsp_tag,
    input  logic                              in_rsp_ready,
    output logic [ptr_width(NUM_ENTRIES)-1:0] pending_count
);
    localparam int ID_W  = id_width(NUM_ENTRIES);
    localparam int PTR_W = ptr_width(NUM_ENTRIES);

    logic [IN_TAG_WIDTH-1:0] tbl_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]  valid_q, valid_d;

    logic             fl_empty, fl_full;
    logic [ID_W-1:0]  alloc_id;
    logic [PTR_W-1:0] free_count;
    logic             alloc_fire, release_fire;
    logic             rsp_in_range, rsp_known;
    logic [ID_W-1:0]  rsp_id;

    // Request side: only reads need a free ID; writes ride through with tag 0.
    assign out_req_valid  = !reset && in_req_valid && (in_req_rw || !fl_empty);
    assign in_req_ready   = !reset && out_req_ready && (in_req_rw || !fl_empty);
    assign out_req_rw     = in_req_rw;
    assign out_req_addr   = in_req_addr;
    assign out_req_data   = in_req_data;
    assign out_req_byteen = in_req_byteen;
    assign out_req_tag    = in_req_rw ? '0 : OUT_TAG_WIDTH'(alloc_id);
    assign alloc_fire     = in_req_valid && in_req_ready && !in_req_rw;

    // Response side: tags that do not name a live entry (stale after reset,
    // or bogus) are accepted unconditionally so they cannot wedge the port.
    assign rsp_id        = out_rsp_tag[ID_W-1:0];
    assign rsp_in_range  = (32'(out_rsp_tag) < 32'(NUM_ENTRIES));
    assign rsp_known     = !reset && rsp_in_range && valid_q[rsp_id];
    assign in_rsp_valid  = out_rsp_valid && rsp_known;
    assign in_rsp_data   = out_rsp_data;
    assign in_rsp_tag    = tbl_q[rsp_id];
    assign out_rsp_ready = rsp_known ? in_rsp_ready : 1'b1;
    assign release_fire  = out_rsp_valid && rsp_known && in_rsp_ready;

    // Valid-bit update; an allocated ID is never the one being released.
    always_comb begin
        valid_d = valid_q;
        if (release_fire) valid_d[rsp_id]   = 1'b0;
        if (alloc_fire)   valid_d[alloc_id] = 1'b1;
    end

    // Tag table and valid vector; reset forgets every outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
            valid_q <= '0;
        end else begin
            if (alloc_fire) tbl_q[alloc_id] <= in_req_tag;
            valid_q <= valid_d;
        end
    end

    vx_mem_tag_remap_freelist #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_freelist (
        .clk     (clk),
        .reset   (reset),
        .pop_en  (alloc_fire),
        .pop_id  (alloc_id),
        .empty   (fl_empty),
        .full    (fl_full),
        .push_en (release_fire),
        .push_id (rsp_id),
        .count   (free_count)
    );

    assign pending_count = PTR_W'(NUM_ENTRIES) - free_count;

    // A returned ID must fit the table and can never overfill the free list.
    // Stale in-range IDs after a reset are expected traffic and are just dropped.
    a_rsp_tag_in_range: assert property (@(posedge clk) disable iff (reset)
        out_rsp_valid |-> rsp_in_range);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        release_fire |-> !fl_full);

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
module tb_vx_mem_tag_remap;
    localparam int DS  = 64;
    localparam int AW  = 26;
    localparam int ITW = 12;
    localparam int N   = 16;
    localparam int OTW = 4;
    localparam int PW  = 5;

    logic            clk, reset;
    logic            in_req_valid, in_req_rw, in_req_ready;
    logic [AW-1:0]   in_req_addr;
    logic [DS*8-1:0] in_req_data;
    logic [DS-1:0]   in_req_byteen;
    logic [ITW-1:0]  in_req_tag;
    logic            out_req_valid, out_req_rw, out_req_ready;
    logic [AW-1:0]   out_req_addr;
    logic [DS*8-1:0] out_req_data;
    logic [DS-1:0]   out_req_byteen;
    logic [OTW-1:0]  out_req_tag;
    logic            out_rsp_valid, out_rsp_ready;
    logic [DS*8-1:0] out_rsp_data;
    logic [OTW-1:0]  out_rsp_tag;
    logic            in_rsp_valid, in_rsp_ready;
    logic [DS*8-1:0] in_rsp_data;
    logic [ITW-1:0]  in_rsp_tag;
    logic [PW-1:0]   pending_count;

    int vectors;
    int miscompares;

    vx_mem_tag_remap #(
        .DATA_SIZE(DS), .ADDR_WIDTH(AW), .IN_TAG_WIDTH(ITW),
        .NUM_ENTRIES(N), .OUT_TAG_WIDTH(OTW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
        .in_req_data(in_req_data), .in_req_byteen(in_req_byteen), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
        .out_req_data(out_req_data), .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
        .out_req_ready(out_req_ready),
        .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
        .out_rsp_ready(out_rsp_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are changed there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step();
        in_req_valid = 1'b1; in_req_rw = 1'b0; in_req_tag = 12'h0AA;
        out_req_ready = 1'b1; out_rsp_valid = 1'b1; out_rsp_tag = 4'd0; in_rsp_ready = 1'b1;
        #2;
        vectors++;
        if ({out_req_valid, in_rsp_valid, out_rsp_ready, pending_count} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got oreqv=%b irspv=%b orspr=%b pend=%0d, want 0 0 1 0",
                     out_req_valid, in_rsp_valid, out_rsp_ready, pending_count);
        end
        in_req_valid = 1'b0; out_rsp_valid = 1'b0;
        reset = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_pending: got %0d want 0", pending_count);
        end
    endtask

    task automatic test_single_read();
        step();
        in_req_valid = 1'b1; in_req_rw = 1'b0; in_req_addr = 26'h2ABCDEF;
        in_req_data = {16{32'hDEADBEEF}}; in_req_byteen = '1; in_req_tag = 12'h123;
        #2;
        vectors++;
        if ({out_req_valid, in_req_ready, out_req_tag} !== {1'b1, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL single_alloc: got v=%b r=%b tag=%0d want 1 1 0",
                     out_req_valid, in_req_ready, out_req_tag);
        end
        vectors++;
        if ({out_req_rw, out_req_addr, out_req_byteen} !== {1'b0, 26'h2ABCDEF, {DS{1'b1}}} ||
            out_req_data !== {16{32'hDEADBEEF}}) begin
            miscompares++;
            $display("FAIL single_passthru: got rw=%b addr=%h want 0 2abcdef", out_req_rw, out_req_addr);
        end
        step();
        in_req_valid = 1'b0;
        out_rsp_valid = 1'b1; out_rsp_tag = 4'd0; out_rsp_data = {8{64'h0123456789ABCDEF}};
        #2;
        vectors++;
        if (pending_count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_pending1: got %0d want 1", pending_count);
        end
        vectors++;
        if ({in_rsp_valid, in_rsp_tag, out_rsp_ready} !== {1'b1, 12'h123, 1'b1} ||
            in_rsp_data !== {8{64'h0123456789ABCDEF}}) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b tag=%h rdy=%b want 1 123 1",
                     in_rsp_valid, in_rsp_tag, out_rsp_ready);
        end
        step();
        out_rsp_valid = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_pending0: got %0d want 0", pending_count);
        end
    endtask

    task automatic test_fill();
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            in_req_valid = 1'b1; in_req_rw = 1'b0; in_req_tag = ITW'(12'h100 + i);
            #2;
            vectors++;
            if ({in_req_ready, out_req_tag} !== {1'b1, OTW'(i)}) begin
                miscompares++;
                $display("FAIL fill_id%0d: got rdy=%b tag=%0d want 1 %0d", i, in_req_ready, out_req_tag, i);
            end
            step();
        end
        in_req_tag = 12'h110;
        #2;
        vectors++;
        if ({in_req_ready, out_req_valid, pending_count} !== {1'b0, 1'b0, 5'd16}) begin
            miscompares++;
            $display("FAIL fill_stall: got rdy=%b v=%b pend=%0d want 0 0 16",
                     in_req_ready, out_req_valid, pending_count);
        end
        in_req_rw = 1'b1; in_req_tag = 12'h007;
        #2;
        vectors++;
        if ({out_req_valid, in_req_ready, out_req_tag} !== {1'b1, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL full_write: got v=%b rdy=%b tag=%0d want 1 1 0",
                     out_req_valid, in_req_ready, out_req_tag);
        end
        step();
        in_req_valid = 1'b0; in_req_rw = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd16) begin
            miscompares++;
            $display("FAIL write_no_alloc: got %0d want 16", pending_count);
        end
    endtask

    task automatic test_out_of_order();
        out_rsp_valid = 1'b1; out_rsp_tag = 4'd5; in_rsp_ready = 1'b1;
        #2;
        vectors++;
        if ({in_rsp_valid, in_rsp_tag} !== {1'b1, 12'h105}) begin
            miscompares++;
            $display("FAIL ooo_rsp5: got v=%b tag=%h want 1 105", in_rsp_valid, in_rsp_tag);
        end
        step();
        out_rsp_tag = 4'd2;
        #2;
        vectors++;
        if ({in_rsp_valid, in_rsp_tag} !== {1'b1, 12'h102}) begin
            miscompares++;
            $display("FAIL ooo_rsp2: got v=%b tag=%h want 1 102", in_rsp_valid, in_rsp_tag);
        end
        step();
        out_rsp_valid = 1'b0;
        in_req_valid = 1'b1; in_req_tag = 12'h200;
        #2;
        vectors++;
        if ({pending_count, out_req_tag} !== {5'd14, 4'd5}) begin
            miscompares++;
            $display("FAIL ooo_reuse5: got pend=%0d id=%0d want 14 5", pending_count, out_req_tag);
        end
        step();
        in_req_tag = 12'h201;
        #2;
        vectors++;
        if (out_req_tag !== 4'd2) begin
            miscompares++;
            $display("FAIL ooo_reuse2: got %0d want 2", out_req_tag);
        end
        step();
        in_req_valid = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd16) begin
            miscompares++;
            $display("FAIL ooo_refull: got %0d want 16", pending_count);
        end
    endtask

    task automatic test_full_same_cycle();
        in_req_valid = 1'b1; in_req_tag = 12'h300;
        out_rsp_valid = 1'b1; out_rsp_tag = 4'd3; in_rsp_ready = 1'b1;
        #2;
        vectors++;
        if ({in_req_ready, in_rsp_valid, in_rsp_tag, pending_count} !== {1'b0, 1'b1, 12'h103, 5'd16}) begin
            miscompares++;
            $display("FAIL same_cycle: got rdy=%b rv=%b tag=%h pend=%0d want 0 1 103 16",
                     in_req_ready, in_rsp_valid, in_rsp_tag, pending_count);
        end
        step();
        out_rsp_valid = 1'b0;
        #2;
        vectors++;
        if ({pending_count, in_req_ready, out_req_tag} !== {5'd15, 1'b1, 4'd3}) begin
            miscompares++;
            $display("FAIL same_cycle_next: got pend=%0d rdy=%b id=%0d want 15 1 3",
                     pending_count, in_req_ready, out_req_tag);
        end
        step();
        in_req_valid = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd16) begin
            miscompares++;
            $display("FAIL same_cycle_refull: got %0d want 16", pending_count);
        end
    endtask

    task automatic test_rsp_backpressure();
        out_rsp_valid = 1'b1; out_rsp_tag = 4'd5; in_rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            vectors++;
            if ({out_rsp_ready, in_rsp_valid, in_rsp_tag, pending_count} !== {1'b0, 1'b1, 12'h200, 5'd16}) begin
                miscompares++;
                $display("FAIL rsp_hold%0d: got rdy=%b v=%b tag=%h pend=%0d want 0 1 200 16",
                         c, out_rsp_ready, in_rsp_valid, in_rsp_tag, pending_count);
            end
            step();
        end
        in_rsp_ready = 1'b1;
        #2;
        vectors++;
        if (out_rsp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_release_rdy: got %b want 1", out_rsp_ready);
        end
        step();
        out_rsp_valid = 1'b0;
        in_req_valid = 1'b1; in_req_tag = 12'h400;
        #2;
        vectors++;
        if ({pending_count, in_req_ready, out_req_tag} !== {5'd15, 1'b1, 4'd5}) begin
            miscompares++;
            $display("FAIL rsp_freed: got pend=%0d rdy=%b id=%0d want 15 1 5",
                     pending_count, in_req_ready, out_req_tag);
        end
        step();
        in_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            in_req_valid = 1'b1; in_req_tag = ITW'(12'h050 + i);
            step();
        end
        in_req_valid = 1'b0;
        #2;
        vectors++;
        if (pending_count !== 5'd3) begin
            miscompares++;
            $display("FAIL mid_pending3: got %0d want 3", pending_count);
        end
        reset = 1'b1;
        in_req_valid = 1'b1; in_req_tag = 12'h0EE;
        out_rsp_valid = 1'b1; out_rsp_tag = 4'd0; in_rsp_ready = 1'b1;
        #2;
        vectors++;
        if ({in_rsp_valid, out_rsp_ready, out_req_valid, pending_count} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL mid_in_reset: got rv=%b rr=%b qv=%b pend=%0d want 0 1 0 0",
                     in_rsp_valid, out_rsp_ready, out_req_valid, pending_count);
        end
        step();
        in_req_valid = 1'b0;
        reset = 1'b0;
        in_rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            out_rsp_tag = OTW'(j);
            #2;
            vectors++;
            if ({in_rsp_valid, out_rsp_ready} !== {1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL stale_drop%0d: got v=%b rdy=%b want 0 1", j, in_rsp_valid, out_rsp_ready);
            end
            step();
        end
        out_rsp_valid = 1'b0; in_rsp_ready = 1'b1;
        in_req_valid = 1'b1; in_req_tag = 12'h060;
        #2;
        vectors++;
        if ({pending_count, out_req_tag} !== {5'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL post_reset_id0: got pend=%0d id=%0d want 0 0", pending_count, out_req_tag);
        end
        step();
        in_req_tag = 12'h061;
        #2;
        vectors++;
        if ({pending_count, out_req_tag} !== {5'd1, 4'd1}) begin
            miscompares++;
            $display("FAIL post_reset_id1: got pend=%0d id=%0d want 1 1", pending_count, out_req_tag);
        end
        step();
        in_req_valid = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        in_req_valid = 1'b0; in_req_rw = 1'b0; in_req_addr = '0; in_req_data = '0;
        in_req_byteen = '0; in_req_tag = '0; out_req_ready = 1'b0;
        out_rsp_valid = 1'b0; out_rsp_data = '0; out_rsp_tag = '0; in_rsp_ready = 1'b0;

        test_reset();
        test_single_read();
        test_fill();
        test_out_of_order();
        test_full_same_cycle();
        test_rsp_backpressure();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
